// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - main control FSM of the multicycle RV32I core
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unknown opcodes park in TRAP and raise illegal).
module multicycle_control_fsm #(
  parameter int USE_MEM_READY = 1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [STATE_W-1:0] state
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic               illegal
`endif
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JAL,
    S_BEQ
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    S_TRAP
`endif
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   rdy;
  logic   pc_update;
  logic   branch;
  logic   ir_write_c;
  logic   mem_write_c;
  logic   reg_write_c;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic   illegal_c;
`endif

  assign rdy   = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = S_FETCH;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_c   = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_c = rdy;
        pc_update  = rdy;
        state_d    = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // PC+imm goes into ALUOut now so BEQ can use it as the target
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1101111:             state_d = S_JAL;
          7'b1100011:             state_d = S_BEQ;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:                state_d = S_TRAP;
`else
          default:                state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == 7'b0000011) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        state_d     = rdy ? S_FETCH : S_MEMWR;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_c = 1'b1;
        state_d   = S_TRAP;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are qualified by reset so nothing fires while reset is held low
  assign pc_write  = reset & (pc_update | (branch & zero));
  assign ir_write  = reset & ir_write_c;
  assign mem_write = reset & mem_write_c;
  assign reg_write = reset & reg_write_c;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal   = illegal_c;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - bench for multicycle_control_fsm (vector table, corner sequences, random vs model)
module tb_multicycle_control_fsm;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4, S_MEMWR = 5;
  localparam int S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_JAL = 9, S_BEQ = 10, S_TRAP = 11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = 7'h33;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;
  logic       illegal_obs;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
  assign illegal_obs = illegal;
`else
  assign illegal_obs = 1'b0;
`endif

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_write(mem_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [16:0] act;
  assign act = {state, pc_write, ir_write, adr_src, mem_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op};

  typedef struct {
    logic        rst;
    logic [6:0]  opc;
    logic        z;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;
  vec_t tv[$];

  function automatic logic [16:0] ex(int st, bit pcw, bit irw, bit adr, bit mw, bit rw,
                                     logic [1:0] rs, logic [1:0] a, logic [1:0] b, logic [1:0] op);
    return {4'(st), pcw, irw, adr, mw, rw, rs, a, b, op};
  endfunction

  function automatic vec_t mk(logic rst, logic [6:0] opc, logic z, logic rdy, logic [16:0] e);
    vec_t v;
    v.rst = rst; v.opc = opc; v.z = z; v.rdy = rdy; v.exp = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [16:0] a, input logic [16:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic check_ill(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: illegal got %b want %b", nm, a, e);
    end
  endtask

  // Reference: expected controls of each named step, straight from the state table
  function automatic logic [16:0] exp_out(int st, logic z, logic rdy, logic rst);
    logic [16:0] e;
    case (st)
      S_FETCH:  e = ex(S_FETCH, rdy, rdy, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00);
      S_DECODE: e = ex(S_DECODE, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
      S_MEMADR: e = ex(S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
      S_MEMRD:  e = ex(S_MEMRD, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      S_MEMWB:  e = ex(S_MEMWB, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00);
      S_MEMWR:  e = ex(S_MEMWR, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      S_EXECR:  e = ex(S_EXECR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
      S_EXECI:  e = ex(S_EXECI, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10);
      S_ALUWB:  e = ex(S_ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
      S_JAL:    e = ex(S_JAL, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
      S_BEQ:    e = ex(S_BEQ, z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01);
      default:  e = ex(S_TRAP, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    endcase
    if (!rst) e[12:9] = 4'b0000;
    return e;
  endfunction

  // Reference: sequence of steps an instruction walks after FETCH, by opcode class
  function automatic void path_for(input logic [6:0] opc, output int p[$]);
    case (opc)
      7'h03:   p = '{S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
      7'h23:   p = '{S_DECODE, S_MEMADR, S_MEMWR};
      7'h33:   p = '{S_DECODE, S_EXECR, S_ALUWB};
      7'h13:   p = '{S_DECODE, S_EXECI, S_ALUWB};
      7'h6F:   p = '{S_DECODE, S_JAL, S_ALUWB};
      7'h63:   p = '{S_DECODE, S_BEQ};
`ifdef CTRL_ILLEGAL_TRAP_EN
      default: p = '{S_DECODE, S_TRAP};
`else
      default: p = '{S_DECODE};
`endif
    endcase
  endfunction

  task automatic step(input logic r, input logic [6:0] o, input logic z, input logic rd);
    @(negedge clk);
    reset = r; opcode = o; zero = z; mem_ready = rd;
    #1;
  endtask

  logic [16:0] F_RST, F_GO, DEC, MADR, MRD, MWB, MWR, EXR, EXI, AWB, JALV, BEQ1, BEQ0, TRAPV;

  initial begin
    int m_step;
    int path[$];
    logic r, z, rd;
    logic [6:0] o;

    F_RST = ex(S_FETCH, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00);
    F_GO  = ex(S_FETCH, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00);
    DEC   = ex(S_DECODE, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
    MADR  = ex(S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
    MRD   = ex(S_MEMRD, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    MWB   = ex(S_MEMWB, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    MWR   = ex(S_MEMWR, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    EXR   = ex(S_EXECR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
    EXI   = ex(S_EXECI, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10);
    AWB   = ex(S_ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    JALV  = ex(S_JAL, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
    BEQ1  = ex(S_BEQ, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01);
    BEQ0  = ex(S_BEQ, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01);
    TRAPV = ex(S_TRAP, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);

    // reset, lw, stalled sw, beq taken/not, jal, R, I, fetch stall
    tv.push_back(mk(0, 7'h33, 0, 1, F_RST)); tv.push_back(mk(0, 7'h33, 0, 1, F_RST));
    tv.push_back(mk(1, 7'h03, 0, 1, F_GO));  tv.push_back(mk(1, 7'h03, 0, 1, DEC));
    tv.push_back(mk(1, 7'h03, 0, 1, MADR));  tv.push_back(mk(1, 7'h03, 0, 1, MRD));
    tv.push_back(mk(1, 7'h03, 0, 1, MWB));
    tv.push_back(mk(1, 7'h23, 0, 1, F_GO));  tv.push_back(mk(1, 7'h23, 0, 1, DEC));
    tv.push_back(mk(1, 7'h23, 0, 1, MADR));  tv.push_back(mk(1, 7'h23, 0, 0, MWR));
    tv.push_back(mk(1, 7'h23, 0, 0, MWR));   tv.push_back(mk(1, 7'h23, 0, 0, MWR));
    tv.push_back(mk(1, 7'h23, 0, 1, MWR));
    tv.push_back(mk(1, 7'h63, 1, 1, F_GO));  tv.push_back(mk(1, 7'h63, 1, 1, DEC));
    tv.push_back(mk(1, 7'h63, 1, 1, BEQ1));
    tv.push_back(mk(1, 7'h63, 0, 1, F_GO));  tv.push_back(mk(1, 7'h63, 0, 1, DEC));
    tv.push_back(mk(1, 7'h63, 0, 1, BEQ0));
    tv.push_back(mk(1, 7'h6F, 0, 1, F_GO));  tv.push_back(mk(1, 7'h6F, 0, 1, DEC));
    tv.push_back(mk(1, 7'h6F, 1, 1, JALV));  tv.push_back(mk(1, 7'h6F, 0, 1, AWB));
    tv.push_back(mk(1, 7'h33, 0, 1, F_GO));  tv.push_back(mk(1, 7'h33, 0, 1, DEC));
    tv.push_back(mk(1, 7'h33, 0, 1, EXR));   tv.push_back(mk(1, 7'h33, 0, 1, AWB));
    tv.push_back(mk(1, 7'h13, 0, 0, F_RST)); tv.push_back(mk(1, 7'h13, 0, 1, F_GO));
    tv.push_back(mk(1, 7'h13, 0, 1, DEC));   tv.push_back(mk(1, 7'h13, 0, 1, EXI));
    tv.push_back(mk(1, 7'h13, 0, 1, AWB));   tv.push_back(mk(1, 7'h13, 0, 1, F_GO));

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst, tv[i].opc, tv[i].z, tv[i].rdy);
      check($sformatf("vec%0d", i), act, tv[i].exp);
    end

    // reset asserted mid-cycle during a stalled store
    step(0, 7'h23, 0, 1); step(1, 7'h23, 0, 1); check("rst_mid_fetch", act, F_GO);
    step(1, 7'h23, 0, 1); step(1, 7'h23, 0, 1); step(1, 7'h23, 0, 0);
    check("rst_mid_memwr", act, MWR);
    #2 reset = 0; #1;
    check("rst_mid_async", act, F_RST);

    // unknown opcode
    step(1, 7'h7F, 0, 1); check("ill_fetch", act, F_GO);
    step(1, 7'h7F, 0, 1); check("ill_decode", act, DEC);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      step(1, 7'h7F, 0, 1);
      check($sformatf("trap%0d", i), act, TRAPV);
      check_ill($sformatf("trap_ill%0d", i), illegal_obs, 1'b1);
    end
    step(0, 7'h7F, 0, 1); check("trap_reset", act, F_RST);
    check_ill("trap_reset_ill", illegal_obs, 1'b0);
`else
    step(1, 7'h7F, 0, 1); check("ill_nop", act, F_GO);
    check_ill("ill_low", illegal_obs, 1'b0);
    step(0, 7'h7F, 0, 1);
`endif

    // random traffic against the path model
    m_step = S_FETCH;
    path.delete();
    o = 7'h33;
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 99) != 0);
      z  = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 3) != 0);
      if (m_step == S_FETCH) begin
        case ($urandom_range(0, 7))
          0: o = 7'h03; 1: o = 7'h23; 2: o = 7'h33; 3: o = 7'h13;
          4: o = 7'h6F; 5: o = 7'h63; 6: o = 7'($urandom); default: o = 7'h7F;
        endcase
      end
      step(r, o, z, rd);
      if (!r) begin
        m_step = S_FETCH;
        path.delete();
      end
      check($sformatf("rnd%0d st%0d", c, m_step), act, exp_out(m_step, z, rd, r));
      check_ill($sformatf("rnd_ill%0d", c), illegal_obs, (m_step == S_TRAP));
      if (r) begin
        if (m_step == S_FETCH) begin
          if (rd) begin
            path_for(o, path);
            m_step = path.pop_front();
          end
        end else if ((m_step == S_MEMRD || m_step == S_MEMWR) && !rd) begin
          m_step = m_step;
        end else if (m_step == S_TRAP) begin
          m_step = S_TRAP;
        end else if (path.size() > 0) begin
          m_step = path.pop_front();
        end else begin
          m_step = S_FETCH;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
